// File: rtl/turn_input_conditioner.sv
// turn_input_conditioner
//
// Conditions the three raw turn-signal contacts (left stalk, right stalk,
// hazard pushbutton) into clean registered levels for the taillight
// controller.
//
// Each raw contact passes through three stages:
//   two-flop synchronizer -> per-channel debounce counter -> registered output
// A clean raw edge reaches its output DEBOUNCE_CYCLES+3 rising edges after
// the first edge that samples it.
//
// The hazard channel drives a toggle latch. Each accepted press flips the
// latch. Releasing the button has no effect, and neither does the time it is
// held.
//
// When both directions are debounced high, conflict is raised and left and
// right are forced low. haz is unaffected. left and right are never gated by
// haz, because hazard priority is resolved downstream.
//
// Optional comfort-turn feature (macro TURN_TAP_LATCH_EN):
//   A debounced rising edge on a direction loads that direction's hold
//   counter with TAP_HOLD_CYCLES. The direction then stays asserted until the
//   counter runs out, even if the stalk has already been released.
//   - A rising edge on the other direction cancels the hold.
//   - A conflict clears both holds.
//   Without the macro there are no hold counters and TAP_HOLD_CYCLES is
//   ignored.
//
// Parameters:
//   DEBOUNCE_CYCLES  consecutive mismatch cycles needed to accept a level (>= 2)
//   TAP_HOLD_CYCLES  comfort-turn hold length in clocks (>= 1)
//
// Ports:
//   clk        in   system clock, rising edge
//   rst        in   synchronous active-high reset
//   raw_left   in   left stalk contact (async, bouncy)
//   raw_right  in   right stalk contact (async, bouncy)
//   raw_haz    in   hazard pushbutton (async, bouncy, momentary)
//   left       out  clean left request
//   right      out  clean right request
//   haz        out  hazard latch state
//   conflict   out  both directions debounced active
module turn_input_conditioner #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int TAP_HOLD_CYCLES = 1000
) (
  input  logic clk,
  input  logic rst,
  input  logic raw_left,
  input  logic raw_right,
  input  logic raw_haz,
  output logic left,
  output logic right,
  output logic haz,
  output logic conflict
);

  // Channel indices into the per-channel vectors.
  localparam int CH_L = 0;
  localparam int CH_R = 1;
  localparam int CH_H = 2;

  localparam int CW = $clog2(DEBOUNCE_CYCLES) + 1;

  // The level is accepted on the cycle when the counter already holds
  // DEBOUNCE_CYCLES-1, which is the DEBOUNCE_CYCLES-th consecutive mismatch.
  localparam logic [CW-1:0] DEB_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [2:0]         raw;
  logic [2:0]         sync1_q;
  logic [2:0]         sync2_q;
  logic [2:0]         deb_q;
  logic [2:0]         deb_d;
  logic [2:0][CW-1:0] cnt_q;
  logic [2:0][CW-1:0] cnt_d;
  logic [2:0]         rise;

  logic haz_latch_q;
  logic haz_latch_d;
  logic both_active;

  logic left_q;
  logic left_d;
  logic right_q;
  logic right_d;
  logic haz_q;
  logic conflict_q;
  logic conflict_d;

  assign raw = {raw_haz, raw_right, raw_left};

  // Debounce: count consecutive mismatch cycles. Any matching cycle clears
  // the count, so a glitch shorter than DEBOUNCE_CYCLES never gets through.
  always_comb begin
    deb_d = deb_q;
    cnt_d = '0;
    for (int i = 0; i < 3; i++) begin
      if (sync2_q[i] != deb_q[i]) begin
        if (cnt_q[i] == DEB_LAST) begin
          deb_d[i] = sync2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + 1'b1;
        end
      end
    end
  end

  // Rising edge of the debounced level. It is taken from the next-state
  // value so that the edge is acted on in the same cycle that deb_q updates.
  assign rise = deb_d & ~deb_q;

  assign haz_latch_d = haz_latch_q ^ rise[CH_H];
  assign both_active = deb_q[CH_L] & deb_q[CH_R];
  assign conflict_d  = both_active;

`ifdef TURN_TAP_LATCH_EN
  localparam int HW = $clog2(TAP_HOLD_CYCLES) + 1;
  localparam logic [HW-1:0] HOLD_INIT = HW'(TAP_HOLD_CYCLES);

  logic [HW-1:0] hold_l_q;
  logic [HW-1:0] hold_l_d;
  logic [HW-1:0] hold_r_q;
  logic [HW-1:0] hold_r_d;

  // Clearing takes priority over loading. If both directions rise in the
  // same cycle, neither hold starts; the conflict that follows would clear
  // them anyway.
  always_comb begin
    hold_l_d = hold_l_q;
    if (both_active || rise[CH_R]) begin
      hold_l_d = '0;
    end else if (rise[CH_L]) begin
      hold_l_d = HOLD_INIT;
    end else if (hold_l_q != '0) begin
      hold_l_d = hold_l_q - 1'b1;
    end
  end

  always_comb begin
    hold_r_d = hold_r_q;
    if (both_active || rise[CH_L]) begin
      hold_r_d = '0;
    end else if (rise[CH_R]) begin
      hold_r_d = HOLD_INIT;
    end else if (hold_r_q != '0) begin
      hold_r_d = hold_r_q - 1'b1;
    end
  end

  assign left_d  = (deb_q[CH_L] | (hold_l_q != '0)) & ~deb_q[CH_R];
  assign right_d = (deb_q[CH_R] | (hold_r_q != '0)) & ~deb_q[CH_L];

  always_ff @(posedge clk) begin
    if (rst) begin
      hold_l_q <= '0;
      hold_r_q <= '0;
    end else begin
      hold_l_q <= hold_l_d;
      hold_r_q <= hold_r_d;
    end
  end
`else
  // No comfort-turn holds in this build; the hold length has no effect.
  logic unused_tap_cfg;
  assign unused_tap_cfg = ^TAP_HOLD_CYCLES;

  assign left_d  = deb_q[CH_L] & ~deb_q[CH_R];
  assign right_d = deb_q[CH_R] & ~deb_q[CH_L];
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q     <= '0;
      sync2_q     <= '0;
      deb_q       <= '0;
      cnt_q       <= '0;
      haz_latch_q <= 1'b0;
      left_q      <= 1'b0;
      right_q     <= 1'b0;
      haz_q       <= 1'b0;
      conflict_q  <= 1'b0;
    end else begin
      sync1_q     <= raw;
      sync2_q     <= sync1_q;
      deb_q       <= deb_d;
      cnt_q       <= cnt_d;
      haz_latch_q <= haz_latch_d;
      left_q      <= left_d;
      right_q     <= right_d;
      haz_q       <= haz_latch_q;
      conflict_q  <= conflict_d;
    end
  end

  assign left     = left_q;
  assign right    = right_q;
  assign haz      = haz_q;
  assign conflict = conflict_q;

endmodule

// File: tb/tb_turn_input_conditioner.sv
// Bench for turn_input_conditioner with DEBOUNCE_CYCLES=4 and
// TAP_HOLD_CYCLES=20, so a clean edge appears 7 edges after it is driven.
// Each output sample is packed as {left, right, haz, conflict}.
// Inputs are driven, and outputs sampled, 1 time unit after each rising edge.
module tb_turn_input_conditioner;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic raw_left = 1'b0;
  logic raw_right = 1'b0;
  logic raw_haz = 1'b0;
  logic left;
  logic right;
  logic haz;
  logic conflict;

  int n_checks = 0;
  int n_fail = 0;
  logic [3:0] exp_q[$];

  typedef struct {
    logic l;
    logic r;
    logic h;
    int unsigned hold;
    logic [3:0] exp;
  } vec_t;

  vec_t vecs[12];

  turn_input_conditioner #(
    .DEBOUNCE_CYCLES(4),
    .TAP_HOLD_CYCLES(20)
  ) dut (
    .clk(clk),
    .rst(rst),
    .raw_left(raw_left),
    .raw_right(raw_right),
    .raw_haz(raw_haz),
    .left(left),
    .right(right),
    .haz(haz),
    .conflict(conflict)
  );

  // Clock and reset.
  always #5 clk = ~clk;

  // Driver tasks.
  task automatic drive(input logic l, input logic r, input logic h);
    raw_left  = l;
    raw_right = r;
    raw_haz   = h;
  endtask

  // Advance one edge. When chk is set, the expected value is queued before
  // the edge and then popped and compared against the DUT after it.
  task automatic cycle(input logic chk, input logic [3:0] exp, input string tag);
    logic [3:0] got;
    logic [3:0] want;
    if (chk) exp_q.push_back(exp);
    @(posedge clk);
    #1;
    if (chk) begin
      got  = {left, right, haz, conflict};
      want = exp_q.pop_front();
      n_checks++;
      if (got !== want) begin
        n_fail++;
        $display("FAIL %s: got lrhc=%b expected lrhc=%b at %0t", tag, got, want, $time);
      end
    end
  endtask

  task automatic idle(input int n);
    drive(1'b0, 1'b0, 1'b0);
    repeat (n) cycle(1'b0, 4'b0000, "");
  endtask

  initial begin
    // Reset: outputs must be low from the first edge and must stay low even
    // while raw inputs are active.
    drive(1'b1, 1'b1, 1'b1);
    for (int i = 0; i < 4; i++) cycle(1'b1, 4'b0000, "reset_hold");
    drive(1'b0, 1'b0, 1'b0);
    cycle(1'b1, 4'b0000, "reset_last");
    rst = 1'b0;
    for (int i = 0; i < 8; i++) cycle(1'b1, 4'b0000, "post_reset_idle");

    // Table of steady-state vectors. Each row is held long enough to settle.
    vecs[0]  = '{1'b1, 1'b0, 1'b0, 10, 4'b1000};  // left only
    vecs[1]  = '{1'b1, 1'b1, 1'b0, 10, 4'b0001};  // both: conflict
    vecs[2]  = '{1'b1, 1'b0, 1'b0, 10, 4'b1000};  // right released
    vecs[3]  = '{1'b0, 1'b1, 1'b0, 10, 4'b0100};  // swap to right
    vecs[4]  = '{1'b0, 1'b0, 1'b1, 10, 4'b0010};  // haz press: latch on
    vecs[5]  = '{1'b0, 1'b0, 1'b0, 10, 4'b0010};  // release: no change
    vecs[6]  = '{1'b0, 1'b1, 1'b1, 10, 4'b0100};  // press again: latch off
    vecs[7]  = '{1'b1, 1'b1, 1'b0, 10, 4'b0001};  // conflict, haz stays off
    vecs[8]  = '{1'b1, 1'b1, 1'b1, 10, 4'b0011};  // haz on alongside conflict
    vecs[9]  = '{1'b0, 1'b0, 1'b0, 10, 4'b0010};  // all released
    vecs[10] = '{1'b0, 1'b0, 1'b1, 10, 4'b0000};  // haz off
    vecs[11] = '{1'b0, 1'b0, 1'b0, 10, 4'b0000};
    for (int i = 0; i < 12; i++) begin
      drive(vecs[i].l, vecs[i].r, vecs[i].h);
      repeat (vecs[i].hold - 1) cycle(1'b0, 4'b0000, "");
      cycle(1'b1, vecs[i].exp, $sformatf("vec%0d", i));
    end
    idle(40);

    // Left rises exactly 7 edges after the raw edge.
    drive(1'b1, 1'b0, 1'b0);
    for (int c = 1; c <= 6; c++) cycle(1'b1, 4'b0000, "left_latency_low");
    cycle(1'b1, 4'b1000, "left_latency_rise");
    idle(40);

    // A 3-cycle pulse is rejected.
    drive(1'b1, 1'b0, 1'b0);
    for (int c = 1; c <= 3; c++) cycle(1'b1, 4'b0000, "pulse3");
    drive(1'b0, 1'b0, 1'b0);
    for (int c = 1; c <= 10; c++) cycle(1'b1, 4'b0000, "pulse3_after");

    // Right toggles every 2 cycles for 20 cycles, then is held high.
    for (int c = 0; c < 20; c++) begin
      drive(1'b0, ((c / 2) % 2) == 0, 1'b0);
      cycle(1'b1, 4'b0000, "bounce_quiet");
    end
    drive(1'b0, 1'b1, 1'b0);
    for (int c = 1; c <= 6; c++) cycle(1'b1, 4'b0000, "bounce_settle_low");
    for (int c = 1; c <= 5; c++) cycle(1'b1, 4'b0100, "bounce_settle_high");
    idle(40);

    // Hazard: a 10-cycle press turns the latch on. A 200-cycle press toggles
    // it exactly once, off.
    drive(1'b0, 1'b0, 1'b1);
    for (int c = 1; c <= 6; c++) cycle(1'b1, 4'b0000, "haz1_low");
    for (int c = 7; c <= 10; c++) cycle(1'b1, 4'b0010, "haz1_high");
    drive(1'b0, 1'b0, 1'b0);
    for (int c = 1; c <= 10; c++) cycle(1'b1, 4'b0010, "haz1_release");
    drive(1'b0, 1'b0, 1'b1);
    for (int c = 1; c <= 6; c++) cycle(1'b1, 4'b0010, "haz2_before");
    for (int c = 7; c <= 200; c++) cycle(c % 10 == 0, 4'b0000, "haz2_held");
    drive(1'b0, 1'b0, 1'b0);
    for (int c = 1; c <= 10; c++) cycle(1'b1, 4'b0000, "haz2_release");
    idle(10);

    // Conflict, then release of right hands over to left after 7 edges.
    drive(1'b1, 1'b1, 1'b0);
    for (int c = 1; c <= 9; c++) cycle(1'b0, 4'b0000, "");
    cycle(1'b1, 4'b0001, "conflict_both");
    drive(1'b1, 1'b0, 1'b0);
    for (int c = 1; c <= 6; c++) cycle(1'b1, 4'b0001, "conflict_release_low");
    cycle(1'b1, 4'b1000, "conflict_release_left");
    idle(40);

`ifdef TURN_TAP_LATCH_EN
    // Comfort turn: an 8-cycle left tap gives exactly 20 cycles of left.
    drive(1'b1, 1'b0, 1'b0);
    for (int c = 1; c <= 40; c++) begin
      if (c == 9) drive(1'b0, 1'b0, 1'b0);
      cycle(1'b1, (c >= 7 && c <= 26) ? 4'b1000 : 4'b0000, "tap_left");
    end
    idle(10);

    // A right tap during the left hold cancels left and starts right's hold.
    drive(1'b1, 1'b0, 1'b0);
    for (int c = 1; c <= 45; c++) begin
      if (c == 9) drive(1'b0, 1'b0, 1'b0);
      if (c == 13) drive(1'b0, 1'b1, 1'b0);
      if (c == 21) drive(1'b0, 1'b0, 1'b0);
      cycle(1'b1, (c >= 7 && c <= 18) ? 4'b1000 :
                  (c >= 19 && c <= 38) ? 4'b0100 : 4'b0000, "tap_override");
    end
    idle(10);
`endif

    // Reset mid-debounce while haz is on. After release the held inputs are
    // accepted again from scratch.
    drive(1'b0, 1'b0, 1'b1);
    for (int c = 1; c <= 9; c++) cycle(1'b0, 4'b0000, "");
    cycle(1'b1, 4'b0010, "rst_pre_haz");
    drive(1'b1, 1'b0, 1'b1);
    for (int c = 1; c <= 4; c++) cycle(1'b1, 4'b0010, "rst_pre_debounce");
    rst = 1'b1;
    cycle(1'b1, 4'b0000, "rst_mid_first");
    cycle(1'b1, 4'b0000, "rst_mid_second");
    rst = 1'b0;
    for (int c = 1; c <= 6; c++) cycle(1'b1, 4'b0000, "rst_reaccept_low");
    cycle(1'b1, 4'b1010, "rst_reaccept");
    for (int c = 1; c <= 5; c++) cycle(1'b1, 4'b1010, "rst_reaccept_hold");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/turn_input_conditioner.md
TURN_INPUT_CONDITIONER -- requirements
Module: turn_input_conditioner

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 16, the number of consecutive cycles a synchronized raw level must differ from the debounced level before it is accepted (minimum 2).
REQ-002 SHALL have parameter TAP_HOLD_CYCLES, default 1000, the comfort-turn hold length in clocks (minimum 1); used only under TAP_LATCH_EN.
REQ-003 SHALL have port clk  input  1  system clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port raw_left  input  1  left stalk contact, asynchronous, may bounce.
REQ-006 SHALL have port raw_right  input  1  right stalk contact, asynchronous, may bounce.
REQ-007 SHALL have port raw_haz  input  1  hazard pushbutton, momentary, asynchronous, may bounce.
REQ-008 SHALL have ports left, right, haz  output  1 each  clean registered levels that drive the left, right and haz inputs of the taillight controller.
REQ-009 SHALL have port conflict  output  1  registered; high while left and right are both debounced active.

Function
REQ-010 SHALL pass each raw input through a two-flop synchronizer before any other logic.
REQ-011 SHALL debounce each channel independently: the counter increments each cycle the synchronized level differs from the debounced level, clears on any cycle they match, and the debounced level takes the new value on the DEBOUNCE_CYCLES-th consecutive mismatch cycle, clearing the counter.
REQ-012 SHALL register all outputs, so a clean raw transition appears on its output after exactly DEBOUNCE_CYCLES+3 rising edges, counting the first edge that samples the new raw level.
REQ-013 SHALL ignore any raw pulse or glitch lasting fewer than DEBOUNCE_CYCLES cycles at the synchronizer output; the output stays unchanged.
REQ-014 SHALL toggle an internal hazard latch on each debounced 0->1 transition of raw_haz only; the button release and the hold duration have no effect. haz equals the latch.
REQ-015 SHALL drive left = debounced_left AND NOT debounced_right, and right = debounced_right AND NOT debounced_left (without TAP_LATCH_EN).
REQ-016 SHALL drive conflict = 1 and left = right = 0 while both directions are debounced active; haz is unaffected.
REQ-017 SHALL NOT gate left/right with haz; hazard priority belongs to the downstream controller.
REQ-018 SHALL saturate nothing and wrap nothing: counters are sized to clog2 of their parameter + 1 and never exceed the parameter value.

Reset
REQ-019 SHALL, on any rising edge with rst = 1, clear synchronizers, debounced levels, all counters, the hazard latch and the hold state to 0.
REQ-020 SHALL present left = right = haz = conflict = 0 after the first reset edge and while rst stays high.
REQ-021 SHALL discard partial debounce counts and active holds on reset mid-operation; after release, an input held high is re-accepted after DEBOUNCE_CYCLES+3 edges.

Configuration
REQ-022 SHALL compile the comfort-turn feature only when macro TURN_TAP_LATCH_EN is defined.
REQ-023 SHALL, with TURN_TAP_LATCH_EN, load a per-direction hold counter with TAP_HOLD_CYCLES on each debounced 0->1 of that direction and decrement it to 0 once per cycle; the direction's output = (debounced level OR hold counter nonzero) AND NOT other direction debounced.
REQ-024 SHALL, with TURN_TAP_LATCH_EN, clear the opposite direction's hold counter on a debounced 0->1 of either direction, and clear both hold counters while conflict is high.
REQ-025 SHALL, without TURN_TAP_LATCH_EN, contain no hold counters; behaviour is exactly REQ-015; TAP_HOLD_CYCLES is ignored.

Verification (DEBOUNCE_CYCLES=4)
REQ-026 SHALL cover: raw_left 0->1 held -> left rises after exactly 7 edges; 3-cycle raw_left pulse -> left stays 0.
REQ-027 SHALL cover: raw_right toggling every 2 cycles for 20 cycles, then held 1 -> right shows a single rise, 7 edges after the last transition, with no earlier activity.
REQ-028 SHALL cover: raw_haz pressed 10 cycles -> haz 1; held 200 cycles on the second press -> exactly one toggle, haz 0.
REQ-029 SHALL cover: raw_left and raw_right both high -> conflict 1 and left = right = 0; release raw_right -> left 1 and conflict 0 after 7 edges.
REQ-030 SHALL cover: TURN_TAP_LATCH_EN with TAP_HOLD_CYCLES=20, raw_left tapped 8 cycles -> left high for exactly 20 cycles; a right tap during the hold -> left drops and right asserts.
REQ-031 SHALL cover: rst asserted mid-debounce and while haz = 1 -> all outputs 0 on the next edge; after release, the held inputs are re-accepted per REQ-021.
